pipe_column_gen: RTL and testbench

Parametrised obstacle-column generator for the Flappy playfield scroller. On each scroll `advance` strobe it produces the next playfield column as a HEIGHT-bit occupancy mask: empty spacing columns, then PIPE_WIDTH identical pipe columns with a gap.
- Gap position comes from an LFSR, not a fixed pattern table.
- Gap height shrinks with progress, giving rising difficulty.
- Columns are handed to the framebuffer writer over a valid/ready handshake.

---
 rtl/pipe_column_gen.sv | 213 +++++++++++++++++++++
 tb/tb_pipe_column_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_column_gen.sv
// ---------------------------------------------------------------------------
// pipe_column_gen
//
// Obstacle-column generator for the Flappy playfield scroller. Every scroll
// advance produces the next playfield column as a HEIGHT-bit occupancy mask:
// SPACING empty columns, then PIPE_WIDTH identical pipe columns with a gap.
// The gap position is drawn from a 16-bit Galois LFSR, and the gap height
// shrinks every SHRINK_EVERY pipes until it reaches GAP_MIN.
//
// Ports:
//   clk          clock
//   resetn       synchronous, active-low reset
//   enable       1 = generation runs, 0 = paused (advances ignored)
//   advance      one-cycle scroll strobe requesting the next column
//   col_ready    consumer accepts col_data while col_valid = 1
//   col_valid    col_data / col_is_pipe hold a column
//   col_data     column mask, bit0 = top row, 1 = pipe, 0 = free
//   col_is_pipe  column belongs to a pipe
//   cur_gap      gap height used for the current/next pipe
//   pipe_count   pipes started since reset (wraps 255 -> 0)
//   overrun      sticky flag: an advance was lost
// ---------------------------------------------------------------------------
module pipe_column_gen #(
    parameter int          HEIGHT       = 30,
    parameter int          GAP_MAX      = 10,
    parameter int          GAP_MIN      = 6,
    parameter int          PIPE_WIDTH   = 2,
    parameter int          SPACING      = 8,
    parameter int          MARGIN       = 2,
    parameter int          SHRINK_EVERY = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic                         advance,
    input  logic                         col_ready,
    output logic                         col_valid,
    output logic [HEIGHT-1:0]            col_data,
    output logic                         col_is_pipe,
    output logic [$clog2(GAP_MAX+1)-1:0] cur_gap,
    output logic [7:0]                   pipe_count,
    output logic                         overrun
);

    localparam int K  = $clog2(HEIGHT);
    localparam int GW = $clog2(GAP_MAX + 1);
    localparam int SW = $clog2(SPACING + 1);
    localparam int PW = $clog2(PIPE_WIDTH + 1);
    localparam int RW = $clog2(SHRINK_EVERY + 1);

    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SPACE,
        S_PIPE
    } state_t;

    state_t            state_q;
    logic [SW-1:0]     space_cnt_q;
    logic [PW-1:0]     pipe_cnt_q;
    logic [RW-1:0]     shrink_cnt_q;
    logic [15:0]       lfsr_q;
    logic [HEIGHT-1:0] mask_q;
    logic [GW-1:0]     gap_q;
    logic [7:0]        pipes_q;
    logic              pending_q;
    logic              pending_d;
    logic              overrun_q;
    logic              overrun_d;
    logic              valid_q;
    logic [HEIGHT-1:0] data_q;
    logic              is_pipe_q;

    logic              slotFree;
    logic              advanceEn;
    logic              load;
    logic [15:0]       lfsrNext;
    logic [HEIGHT-1:0] newMask;
    int                rangeV;
    int                cV;
    int                offV;
    int                gapPos;

    // Handshake bookkeeping: the slot is free when empty or being drained
    // this cycle. A load also needs an outstanding request and a running
    // generator that has left idle. A request consumed by a load while a
    // fresh advance arrives keeps the fresh one pending; a pending request
    // that is neither consumed nor replaceable marks the sticky overrun.
    always_comb begin
        slotFree  = !valid_q || col_ready;
        advanceEn = enable && advance;
        load      = enable && (pending_q || advance) && slotFree && (state_q != S_IDLE);
        pending_d = load ? (pending_q && advanceEn) : (pending_q || advanceEn);
        overrun_d = overrun_q || (pending_q && advanceEn && !load);
    end

    // One Galois step; this is the value a new pipe draws its gap from.
    always_comb begin
        lfsrNext = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    end

    // Gap placement folds the LFSR sample into the legal range once and then
    // clamps, so the gap always keeps MARGIN pipe rows above and below it.
    always_comb begin
        rangeV = HEIGHT - 2 * MARGIN - int'(gap_q) + 1;
        cV     = int'(lfsrNext[K-1:0]);
        offV   = cV;
        if (cV >= rangeV) begin
            offV = cV - rangeV;
            if (offV >= rangeV) begin
                offV = rangeV - 1;
            end
        end
        gapPos = MARGIN + offV;
        newMask = '0;
        for (int i = 0; i < HEIGHT; i++) begin
            newMask[i] = !((i >= gapPos) && (i < gapPos + int'(gap_q)));
        end
    end

    // Column FSM with registered outputs. Every emitted column goes through
    // 'load'; the first column of a pipe steps the LFSR and latches the mask
    // so the remaining pipe columns repeat it even across a pause. Difficulty
    // is updated on the last column so the new gap applies to the next pipe.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            space_cnt_q  <= '0;
            pipe_cnt_q   <= '0;
            shrink_cnt_q <= '0;
            lfsr_q       <= SEED;
            mask_q       <= '0;
            gap_q        <= GW'(GAP_MAX);
            pipes_q      <= 8'd0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            is_pipe_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            if (valid_q && col_ready && !load) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q     <= S_SPACE;
                        space_cnt_q <= '0;
                    end
                end
                S_SPACE: begin
                    if (load) begin
                        valid_q   <= 1'b1;
                        data_q    <= '0;
                        is_pipe_q <= 1'b0;
                        if (space_cnt_q == SW'(SPACING - 1)) begin
                            state_q     <= S_PIPE;
                            space_cnt_q <= '0;
                            pipe_cnt_q  <= '0;
                        end else begin
                            space_cnt_q <= space_cnt_q + SW'(1);
                        end
                    end
                end
                S_PIPE: begin
                    if (load) begin
                        valid_q   <= 1'b1;
                        is_pipe_q <= 1'b1;
                        if (pipe_cnt_q == '0) begin
                            lfsr_q  <= lfsrNext;
                            mask_q  <= newMask;
                            data_q  <= newMask;
                            pipes_q <= pipes_q + 8'd1;
                        end else begin
                            data_q <= mask_q;
                        end
                        if (pipe_cnt_q == PW'(PIPE_WIDTH - 1)) begin
                            state_q     <= S_SPACE;
                            space_cnt_q <= '0;
                            pipe_cnt_q  <= '0;
                            if (shrink_cnt_q == RW'(SHRINK_EVERY - 1)) begin
                                shrink_cnt_q <= '0;
                                if (gap_q > GW'(GAP_MIN)) begin
                                    gap_q <= gap_q - GW'(1);
                                end
                            end else begin
                                shrink_cnt_q <= shrink_cnt_q + RW'(1);
                            end
                        end else begin
                            pipe_cnt_q <= pipe_cnt_q + PW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign col_valid   = valid_q;
    assign col_data    = data_q;
    assign col_is_pipe = is_pipe_q;
    assign cur_gap     = gap_q;
    assign pipe_count  = pipes_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_pipe_column_gen.sv
// ---------------------------------------------------------------------------
// tb_pipe_column_gen
//
// Directed testbench for pipe_column_gen with default parameters. Walks
// through spacing/pipe generation, back-pressure and overrun, reset in the
// middle of a pipe, pausing between pipe columns, and a long run checking
// gap shrinking, mask shape and pipe_count wrap.
// ---------------------------------------------------------------------------
module tb_pipe_column_gen;

    localparam int HEIGHT  = 30;
    localparam int GAP_MAX = 10;
    localparam int GAP_MIN = 6;
    localparam int SPACING = 8;
    localparam int MARGIN  = 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic              enable;
    logic              advance;
    logic              col_ready;
    logic              col_valid;
    logic [HEIGHT-1:0] col_data;
    logic              col_is_pipe;
    logic [3:0]        cur_gap;
    logic [7:0]        pipe_count;
    logic              overrun;

    int compareCount  = 0;
    int mismatchCount = 0;

    pipe_column_gen dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .advance    (advance),
        .col_ready  (col_ready),
        .col_valid  (col_valid),
        .col_data   (col_data),
        .col_is_pipe(col_is_pipe),
        .cur_gap    (cur_gap),
        .pipe_count (pipe_count),
        .overrun    (overrun)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Moves one cycle forward and settles just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses advance for one cycle; the column must be in the slot right
    // after that edge.
    task automatic applyStimulus(output logic [HEIGHT-1:0] data, output logic isPipe);
        advance = 1'b1;
        tick();
        advance = 1'b0;
        checkOutput("colValidAfterAdvance", 64'(col_valid), 64'd1);
        data   = col_data;
        isPipe = col_is_pipe;
    endtask

    // Emits the SPACING empty columns preceding a pipe.
    task automatic runSpaces();
        logic [HEIGHT-1:0] d;
        logic              p;
        for (int i = 0; i < SPACING; i++) begin
            applyStimulus(d, p);
            checkOutput("spaceData", 64'(d), 64'd0);
            checkOutput("spaceIsPipe", 64'(p), 64'd0);
        end
    endtask

    // Counts the free rows of a mask and checks they form one block that
    // keeps MARGIN pipe rows at both ends.
    task automatic analyzeMask(input logic [HEIGHT-1:0] m, output int zeros, output logic ok);
        int first;
        int last;
        first = -1;
        last  = -1;
        zeros = 0;
        for (int i = 0; i < HEIGHT; i++) begin
            if (!m[i]) begin
                zeros++;
                if (first < 0) first = i;
                last = i;
            end
        end
        ok = (zeros > 0) && (last - first + 1 == zeros) &&
             (first >= MARGIN) && (last <= HEIGHT - 1 - MARGIN);
    endtask

    function automatic int expectedGap(input int pipesDone);
        int g;
        g = GAP_MAX - pipesDone / 4;
        return (g < GAP_MIN) ? GAP_MIN : g;
    endfunction

    initial begin
        logic [HEIGHT-1:0] d1;
        logic [HEIGHT-1:0] d2;
        logic              p1;
        logic              p2;
        int                zeros;
        logic              shapeOk;
        int                pipesDone;

        resetn    = 1'b0;
        enable    = 1'b0;
        advance   = 1'b0;
        col_ready = 1'b0;
        tick();
        tick();
        checkOutput("resetValid", 64'(col_valid), 64'd0);
        checkOutput("resetData", 64'(col_data), 64'd0);
        checkOutput("resetIsPipe", 64'(col_is_pipe), 64'd0);
        checkOutput("resetGap", 64'(cur_gap), 64'd10);
        checkOutput("resetPipeCount", 64'(pipe_count), 64'd0);
        checkOutput("resetOverrun", 64'(overrun), 64'd0);

        // First pipe: lfsr E270, gap rows 18..27.
        resetn    = 1'b1;
        enable    = 1'b1;
        col_ready = 1'b1;
        tick();
        runSpaces();
        applyStimulus(d1, p1);
        checkOutput("pipe1Col1Data", 64'(d1), 64'h3003FFFF);
        checkOutput("pipe1Col1IsPipe", 64'(p1), 64'd1);
        checkOutput("pipe1Count", 64'(pipe_count), 64'd1);
        applyStimulus(d2, p2);
        checkOutput("pipe1Col2Data", 64'(d2), 64'h3003FFFF);
        checkOutput("pipe1Col2IsPipe", 64'(p2), 64'd1);
        tick();
        checkOutput("validDropsAfterHandshake", 64'(col_valid), 64'd0);

        // Second pipe: lfsr 7138, c=24 folds to off 7, gap rows 9..18.
        runSpaces();
        applyStimulus(d1, p1);
        checkOutput("pipe2Col1Data", 64'(d1), 64'h3FF801FF);
        applyStimulus(d2, p2);
        checkOutput("pipe2Col2Data", 64'(d2), 64'h3FF801FF);
        checkOutput("pipe2Count", 64'(pipe_count), 64'd2);

        // Back-pressure: third pipe (lfsr 389C, gap rows 13..22) is held
        // while two more advances arrive; the second one is lost.
        runSpaces();
        tick();
        col_ready = 1'b0;
        applyStimulus(d1, p1);
        checkOutput("pipe3Col1Data", 64'(d1), 64'h3F801FFF);
        advance = 1'b1;
        tick();
        advance = 1'b0;
        checkOutput("heldDataStable1", 64'(col_data), 64'h3F801FFF);
        checkOutput("overrunAfterFirstPend", 64'(overrun), 64'd0);
        advance = 1'b1;
        tick();
        advance = 1'b0;
        checkOutput("heldDataStable2", 64'(col_data), 64'h3F801FFF);
        checkOutput("heldValid", 64'(col_valid), 64'd1);
        checkOutput("overrunSet", 64'(overrun), 64'd1);
        col_ready = 1'b1;
        tick();
        checkOutput("pendingDeliveredValid", 64'(col_valid), 64'd1);
        checkOutput("pendingDeliveredData", 64'(col_data), 64'h3F801FFF);
        checkOutput("pendingDeliveredIsPipe", 64'(col_is_pipe), 64'd1);
        tick();
        checkOutput("onlyOnePendingColumn", 64'(col_valid), 64'd0);
        checkOutput("overrunSticky", 64'(overrun), 64'd1);
        checkOutput("pipe3Count", 64'(pipe_count), 64'd3);

        // Reset while a pipe column is held, then replay from the seed.
        runSpaces();
        tick();
        col_ready = 1'b0;
        applyStimulus(d1, p1);
        checkOutput("preResetIsPipe", 64'(p1), 64'd1);
        resetn = 1'b0;
        tick();
        checkOutput("midResetValid", 64'(col_valid), 64'd0);
        checkOutput("midResetGap", 64'(cur_gap), 64'd10);
        checkOutput("midResetPipeCount", 64'(pipe_count), 64'd0);
        checkOutput("midResetOverrun", 64'(overrun), 64'd0);
        resetn    = 1'b1;
        col_ready = 1'b1;
        tick();
        runSpaces();
        applyStimulus(d1, p1);
        checkOutput("replayCol1Data", 64'(d1), 64'h3003FFFF);
        applyStimulus(d2, p2);
        checkOutput("replayCol2Data", 64'(d2), 64'h3003FFFF);
        checkOutput("replayPipeCount", 64'(pipe_count), 64'd1);

        // Pause between the two columns of the second pipe.
        runSpaces();
        applyStimulus(d1, p1);
        checkOutput("pauseCol1Data", 64'(d1), 64'h3FF801FF);
        enable = 1'b0;
        tick();
        checkOutput("pauseHandshakeDone", 64'(col_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            advance = 1'b1;
            tick();
            advance = 1'b0;
            tick();
            checkOutput("pauseNoColumn", 64'(col_valid), 64'd0);
        end
        checkOutput("pauseOverrun", 64'(overrun), 64'd0);
        enable = 1'b1;
        tick();
        checkOutput("resumeNoPending", 64'(col_valid), 64'd0);
        applyStimulus(d2, p2);
        checkOutput("resumeCol2Data", 64'(d2), 64'h3FF801FF);
        checkOutput("resumeCol2IsPipe", 64'(p2), 64'd1);
        checkOutput("resumePipeCount", 64'(pipe_count), 64'd2);
        tick();
        checkOutput("resumeNoExtra", 64'(col_valid), 64'd0);
        checkOutput("resumeOverrun", 64'(overrun), 64'd0);

        // Long run: gap shrink schedule, mask shape, pipe_count wrap.
        pipesDone = 2;
        for (int p = 0; p < 300; p++) begin
            runSpaces();
            applyStimulus(d1, p1);
            checkOutput("runIsPipe", 64'(p1), 64'd1);
            checkOutput("runGapInUse", 64'(cur_gap), 64'(expectedGap(pipesDone)));
            analyzeMask(d1, zeros, shapeOk);
            checkOutput("runGapZeros", 64'(zeros), 64'(expectedGap(pipesDone)));
            checkOutput("runGapShape", 64'(shapeOk), 64'd1);
            checkOutput("runPipeCount", 64'(pipe_count), 64'((pipesDone + 1) % 256));
            applyStimulus(d2, p2);
            checkOutput("runCol2Same", 64'(d2), 64'(d1));
            pipesDone++;
            checkOutput("runGapAfterPipe", 64'(cur_gap), 64'(expectedGap(pipesDone)));
            if (pipesDone == 256) begin
                checkOutput("pipeCountWrap", 64'(pipe_count), 64'd0);
            end
        end
        checkOutput("finalGap", 64'(cur_gap), 64'd6);
        checkOutput("finalOverrun", 64'(overrun), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
